// File: rtl/dec_deserializer_22b.sv
// Frame-envelope serial-to-parallel receiver: MSB-first words framed by frame_sync_i,
// with a ready/valid output register, malformed-frame pulse, sticky overrun and good-frame count.
module dec_deserializer_22b #(
  parameter int DATA_W = 22,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ser_data_i,
  input  logic              frame_sync_i,
  input  logic              ready_i,
  input  logic              clear_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              frame_err_o,
  output logic              overrun_o,
  output logic [CNT_W-1:0]  frame_cnt_o
);
  // state    | meaning
  // IDLE     | waiting for a rising edge of the registered frame envelope
  // SHIFT    | capturing bits, MSB first
  // CHECK    | all bits captured; envelope must drop now for a good frame
  // WAIT_LOW | frame ran long; ignore everything until the envelope drops
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, WAIT_LOW} state_t;

  localparam int              BC_W    = $clog2(DATA_W + 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);

  state_t            state_q;
  logic              r_data_q;
  logic              r_sync_q;
  logic              r_sync_dly_q;
  logic              samp_ok_q;
  logic              armed_q;
  logic [DATA_W-1:0] shift_q;
  logic [BC_W-1:0]   bit_cnt_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              frame_err_q;
  logic              overrun_q;
  logic [CNT_W-1:0]  frame_cnt_q;

  logic sync_rise;
  logic load_word;

  // r_sync_q only holds a real sample after the first edge out of reset; armed_q
  // requires a genuine low so a frame already in flight at reset release is skipped.
  assign sync_rise = armed_q & r_sync_q & ~r_sync_dly_q;
  assign load_word = (state_q == CHECK) & ~r_sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      r_data_q     <= 1'b0;
      r_sync_q     <= 1'b0;
      r_sync_dly_q <= 1'b0;
      samp_ok_q    <= 1'b0;
      armed_q      <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      r_data_q     <= ser_data_i;
      r_sync_q     <= frame_sync_i;
      r_sync_dly_q <= r_sync_q;
      samp_ok_q    <= 1'b1;
      if (samp_ok_q && !r_sync_q) armed_q <= 1'b1;
      frame_err_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          if (sync_rise) begin
            shift_q   <= {{(DATA_W-1){1'b0}}, r_data_q};
            bit_cnt_q <= BC_W'(1);
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (r_sync_q) begin
            shift_q   <= {shift_q[DATA_W-2:0], r_data_q};
            bit_cnt_q <= bit_cnt_q + BC_W'(1);
            if (bit_cnt_q == BC_LAST) state_q <= CHECK;
          end else begin
            frame_err_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        CHECK: begin
          if (r_sync_q) begin
            frame_err_q <= 1'b1;
            state_q     <= WAIT_LOW;
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT_LOW: begin
          if (!r_sync_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // A new word may overwrite an accepted one freely; only an unaccepted one is an overrun.
      if (load_word) begin
        data_q      <= shift_q;
        valid_q     <= 1'b1;
        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end

      if (load_word && valid_q && !ready_i) overrun_q <= 1'b1;
      else if (clear_i)                     overrun_q <= 1'b0;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_dec_deserializer_22b.sv
// Bench for dec_deserializer_22b: directed frame scenarios plus randomized frames and
// handshake, checked every cycle against a run-length model of the frame envelope.
module tb_dec_deserializer_22b;
  localparam int DATA_W = 22;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ser_data = 1'b0;
  logic              frame_sync = 1'b0;
  logic              ready = 1'b1;
  logic              clear = 1'b0;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              frame_err_o;
  logic              overrun_o;
  logic [CNT_W-1:0]  frame_cnt_o;

  dec_deserializer_22b #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .ser_data_i   (ser_data),
    .frame_sync_i (frame_sync),
    .ready_i      (ready),
    .clear_i      (clear),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
    .frame_cnt_o  (frame_cnt_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a frame is a run of envelope-high samples that began after a
  // post-reset low sample. Exactly DATA_W highs then a low is good; fewer is short;
  // reaching DATA_W+1 highs is long. Every verdict shows on the outputs one edge later.
  int unsigned m_word = 0;
  int          m_run = 0;
  bit          m_run_ok = 0;
  bit          m_seen_low = 0;
  bit          p_good = 0;
  bit          p_err = 0;
  int unsigned p_word = 0;
  bit          m_valid = 0;
  int unsigned m_data = 0;
  bit          m_err = 0;
  bit          m_ovr = 0;
  int unsigned m_cnt = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_word = 0; m_run = 0; m_run_ok = 0; m_seen_low = 0;
      p_good = 0; p_err = 0; p_word = 0;
      m_valid = 0; m_data = 0; m_err = 0; m_ovr = 0; m_cnt = 0;
    end else begin
      bit ovr_set;
      ovr_set = 0;
      if (p_good) begin
        if (m_valid && !ready) ovr_set = 1;
        m_valid = 1;
        m_data  = p_word;
        m_cnt   = (m_cnt + 1) % (1 << CNT_W);
      end else if (m_valid && ready) begin
        m_valid = 0;
      end
      if (ovr_set) m_ovr = 1;
      else if (clear) m_ovr = 0;
      m_err  = p_err;
      p_good = 0;
      p_err  = 0;

      if (frame_sync) begin
        if (m_run == 0) m_run_ok = m_seen_low;
        m_run++;
        m_word = ((m_word << 1) | ser_data) % (1 << DATA_W);
        if (m_run_ok && m_run == DATA_W + 1) begin
          p_err    = 1;
          m_run_ok = 0;
        end
      end else begin
        if (m_run_ok && m_run == DATA_W) begin
          p_good = 1;
          p_word = m_word;
        end else if (m_run_ok && m_run > 0) begin
          p_err = 1;
        end
        m_run      = 0;
        m_run_ok   = 0;
        m_seen_low = 1;
      end
    end
  end

  int          n_valid = 0;
  int          n_err = 0;
  int unsigned last_data = 0;

  always @(negedge clk) begin
    chk("valid_o", valid_o, m_valid);
    chk("data_o", data_o, m_data);
    chk("frame_err_o", frame_err_o, m_err);
    chk("overrun_o", overrun_o, m_ovr);
    chk("frame_cnt_o", frame_cnt_o, m_cnt);
    if (valid_o) begin
      n_valid++;
      last_data = data_o;
    end
    if (frame_err_o) n_err++;
  end

  bit rnd_hs = 0;

  task automatic step();
    if (rnd_hs) begin
      ready = 1'($urandom_range(0, 1));
      clear = ($urandom_range(0, 7) == 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Drives len envelope-high cycles (bits past DATA_W are random filler), then gap lows.
  // rst_at >= 0 asserts reset at that bit and releases it three bits later.
  task automatic send_frame(input logic [DATA_W-1:0] w, input int len, input int gap,
                            input int rst_at = -1);
    for (int i = 0; i < len; i++) begin
      if (i == rst_at) rst = 1'b1;
      if (rst_at >= 0 && i == rst_at + 3) rst = 1'b0;
      frame_sync = 1'b1;
      ser_data   = (i < DATA_W) ? w[DATA_W-1-i] : 1'($urandom_range(0, 1));
      step();
    end
    frame_sync = 1'b0;
    ser_data   = 1'b0;
    idle(gap);
  endtask

  int v0, e0;

  initial begin
    @(posedge clk);
    #1;
    idle(2);
    chk("rst valid_o", valid_o, 0);
    chk("rst data_o", data_o, 0);
    chk("rst frame_cnt_o", frame_cnt_o, 0);
    chk("rst overrun_o", overrun_o, 0);
    rst = 1'b0;
    idle(3);

    // Clean frame, downstream always ready.
    v0 = n_valid; e0 = n_err;
    send_frame(22'h2AAAAA, 22, 4);
    chk("good valid cycles", n_valid - v0, 1);
    chk("good data", last_data, 32'h2AAAAA);
    chk("good cnt", frame_cnt_o, 1);
    chk("good err pulses", n_err - e0, 0);

    // Short frame.
    v0 = n_valid; e0 = n_err;
    send_frame(22'h3FFFFF, 10, 4);
    chk("short err pulses", n_err - e0, 1);
    chk("short valid cycles", n_valid - v0, 0);
    chk("short cnt", frame_cnt_o, 1);

    // Long frame followed by a clean one.
    v0 = n_valid; e0 = n_err;
    send_frame(22'h155555, 30, 3);
    send_frame(22'h000001, 22, 4);
    chk("long err pulses", n_err - e0, 1);
    chk("long+next valid cycles", n_valid - v0, 1);
    chk("long next data", last_data, 32'h1);
    chk("long cnt", frame_cnt_o, 2);

    // Overrun with downstream stalled, then clear.
    ready = 1'b0;
    send_frame(22'h123456, 22, 2);
    send_frame(22'h3FFFFF, 22, 3);
    chk("ovr data_o", data_o, 32'h3FFFFF);
    chk("ovr valid_o", valid_o, 1);
    chk("ovr overrun_o", overrun_o, 1);
    chk("ovr cnt", frame_cnt_o, 4);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    chk("clear overrun_o", overrun_o, 0);
    ready = 1'b1;
    idle(2);
    chk("drain valid_o", valid_o, 0);

    // Reset at bit 11, released mid-frame.
    v0 = n_valid; e0 = n_err;
    send_frame(22'h0F0F0F, 22, 3, 11);
    chk("midrst err pulses", n_err - e0, 0);
    chk("midrst valid cycles", n_valid - v0, 0);
    chk("midrst cnt", frame_cnt_o, 0);
    send_frame(22'h155555, 22, 3);
    chk("postrst data", last_data, 32'h155555);
    chk("postrst cnt", frame_cnt_o, 1);

    // Back-to-back frames separated by one low cycle.
    v0 = n_valid;
    send_frame(22'h0ABCDE, 22, 1);
    send_frame(22'h3C3C3C, 22, 3);
    chk("b2b valid cycles", n_valid - v0, 2);
    chk("b2b data", last_data, 32'h3C3C3C);

    // Counter wrap: 3 good frames so far, 13 more reach 2^CNT_W.
    for (int i = 0; i < 13; i++) send_frame(DATA_W'($urandom), 22, 1);
    idle(2);
    chk("wrap cnt", frame_cnt_o, 0);

    // Random frames, lengths and handshake.
    rnd_hs = 1;
    for (int i = 0; i < 120; i++) begin
      int sel, len;
      sel = $urandom_range(0, 9);
      if (sel < 7)      len = DATA_W;
      else if (sel < 9) len = $urandom_range(1, DATA_W - 1);
      else              len = $urandom_range(DATA_W + 1, DATA_W + 8);
      send_frame(DATA_W'($urandom), len, $urandom_range(1, 4));
    end
    rnd_hs = 0;
    ready  = 1'b1;
    clear  = 1'b0;
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
